rotary_encoder_ctrl: RTL and testbench



---
 rtl/rotary_encoder_ctrl.sv | 140 ++++++++++++++
 tb/tb_rotary_encoder_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_encoder_ctrl.sv
// Quadrature rotary encoder front end: 2-flop sync, per-channel debounce, detent FSM,
// one-hot LED rotator and position counter. Define ROTARY_SATURATE_EN to clamp position.
module rotary_encoder_ctrl #(
    parameter int NUM_LEDS        = 8,
    parameter int COUNT_WIDTH     = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   input_A,
    input  logic                   input_B,
    input  logic                   mode,
    output logic [NUM_LEDS-1:0]    leds,
    output logic [COUNT_WIDTH-1:0] position,
    output logic                   step_valid,
    output logic                   step_dir
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CW_ARM  = 2'd1,
        CCW_ARM = 2'd2,
        DETENT  = 2'd3
    } state_t;

    // Channel index 1 is A, index 0 is B, so a pair reads as {A,B}.
    logic [1:0]       sync1, sync2, filt;
    logic [CNT_W-1:0] cnt [2];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            filt   <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= {input_A, input_B};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        filt[i] <= sync2[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    state_t state, state_next;
    logic   step_fire, dir_fire;

    always_comb begin
        state_next = state;
        step_fire  = 1'b0;
        dir_fire   = 1'b0;
        case (state)
            IDLE: begin
                case (filt)
                    2'b01:   state_next = CW_ARM;
                    2'b10:   state_next = CCW_ARM;
                    2'b11:   state_next = DETENT;
                    default: state_next = IDLE;
                endcase
            end
            CW_ARM: begin
                case (filt)
                    2'b11: begin
                        state_next = DETENT;
                        step_fire  = 1'b1;
                        dir_fire   = 1'b1;
                    end
                    2'b00:   state_next = IDLE;
                    2'b10:   state_next = CCW_ARM;
                    default: state_next = CW_ARM;
                endcase
            end
            CCW_ARM: begin
                case (filt)
                    2'b11: begin
                        state_next = DETENT;
                        step_fire  = 1'b1;
                    end
                    2'b00:   state_next = IDLE;
                    2'b01:   state_next = CW_ARM;
                    default: state_next = CCW_ARM;
                endcase
            end
            default: begin
                if (filt == 2'b00) state_next = IDLE;
            end
        endcase
    end

    // step_valid is a one-cycle strobe with no back-pressure; step_dir, position and
    // the pattern are already updated while it is high.
    logic [NUM_LEDS-1:0] pattern;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            position   <= '0;
            pattern    <= NUM_LEDS'(1);
        end else begin
            state      <= state_next;
            step_valid <= step_fire;
            if (step_fire) begin
                step_dir <= dir_fire;
                if (dir_fire) begin
`ifdef ROTARY_SATURATE_EN
                    if (position != '1) position <= position + COUNT_WIDTH'(1);
`else
                    position <= position + COUNT_WIDTH'(1);
`endif
                    if (!mode) pattern <= {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
                end else begin
`ifdef ROTARY_SATURATE_EN
                    if (position != '0) position <= position - COUNT_WIDTH'(1);
`else
                    position <= position - COUNT_WIDTH'(1);
`endif
                    if (!mode) pattern <= {pattern[0], pattern[NUM_LEDS-1:1]};
                end
            end
        end
    end

    assign leds = mode ? position[NUM_LEDS-1:0] : pattern;

endmodule

// File: tb/tb_rotary_encoder_ctrl.sv
// Bench for rotary_encoder_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized quadrature traffic checked against a rule-based detent model.
module tb_rotary_encoder_ctrl;

    localparam int NL = 8;
    localparam int CWD = 8;
    localparam int DB = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           input_A, input_B, mode;
    logic [NL-1:0]  leds;
    logic [CWD-1:0] position;
    logic           step_valid, step_dir;

    rotary_encoder_ctrl #(
        .NUM_LEDS(NL), .COUNT_WIDTH(CWD), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock(clock), .reset(reset), .input_A(input_A), .input_B(input_B),
        .mode(mode), .leds(leds), .position(position),
        .step_valid(step_valid), .step_dir(step_dir)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic sb_en = 1'b0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [1:0] ab;
        logic       m;
        logic [7:0] exp_leds;
        logic [7:0] exp_pos;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ab);
        input_A = ab[1];
        input_B = ab[0];
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mode  = 1'b0;
        drive(2'b00);
        hold(3);
        reset = 1'b0;
    endtask

    // Monitor: counts strobes; in scoreboard phase each strobe must match a queued direction.
    always @(negedge clock) begin
        if (step_valid === 1'b1) begin
            pulse_cnt++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step actual=1 expected=0 at %0t", $time);
                end else begin
                    check("rand_step_dir", 32'(step_dir), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int first, p0, pos, idx, prev, nv, b;
        logic latched, m;
        logic [7:0] exp_l, w_pos;

        // Reset state
        do_reset();
        check("rst_leds", 32'(leds), 32'h01);
        check("rst_pos", 32'(position), 32'h00);
        check("rst_valid", 32'(step_valid), 32'h0);
        check("rst_dir", 32'(step_dir), 32'h0);

        // Single CW step and its latency from the raw 11 edge
        drive(2'b01);
        hold(10);
        drive(2'b11);
        first = -1;
        p0 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (step_valid) begin
                p0++;
                if (first < 0) first = k;
            end
        end
        check("step_latency", 32'(first), 32'd7);
        check("step_width", 32'(p0), 32'd1);
        check("cw_dir", 32'(step_dir), 32'h1);
        check("cw_leds", 32'(leds), 32'h02);
        check("cw_pos", 32'(position), 32'h01);
        drive(2'b00);
        hold(10);

        // Vector table from reset
        tbl.push_back('{2'b01, 1'b0, 8'h01, 8'h00});
        tbl.push_back('{2'b11, 1'b0, 8'h02, 8'h01});
        tbl.push_back('{2'b00, 1'b0, 8'h02, 8'h01});
        for (int k = 2; k <= 5; k++) begin
            tbl.push_back('{2'b01, 1'b0, 8'(1 << (k - 1)), 8'(k - 1)});
            tbl.push_back('{2'b11, 1'b0, 8'(1 << k), 8'(k)});
            tbl.push_back('{2'b00, 1'b0, 8'(1 << k), 8'(k)});
        end
        tbl.push_back('{2'b00, 1'b1, 8'h05, 8'h05});
        tbl.push_back('{2'b00, 1'b0, 8'h20, 8'h05});
        for (int k = 1; k <= 3; k++) begin
            tbl.push_back('{2'b10, 1'b0, 8'(8'h20 >> (k - 1)), 8'(6 - k)});
            tbl.push_back('{2'b11, 1'b0, 8'(8'h20 >> k), 8'(5 - k)});
            tbl.push_back('{2'b00, 1'b0, 8'(8'h20 >> k), 8'(5 - k)});
        end
        tbl.push_back('{2'b11, 1'b0, 8'h04, 8'h02});
        tbl.push_back('{2'b00, 1'b0, 8'h04, 8'h02});
        tbl.push_back('{2'b01, 1'b1, 8'h02, 8'h02});
        tbl.push_back('{2'b11, 1'b1, 8'h03, 8'h03});
        tbl.push_back('{2'b00, 1'b0, 8'h04, 8'h03});
        do_reset();
        foreach (tbl[i]) begin
            mode = tbl[i].m;
            drive(tbl[i].ab);
            hold(10);
            check($sformatf("tbl%0d_leds", i), 32'(leds), 32'(tbl[i].exp_leds));
            check($sformatf("tbl%0d_pos", i), 32'(position), 32'(tbl[i].exp_pos));
        end

        // Three CCW steps from reset: wrap or clamp below zero
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(2'b10); hold(10);
            drive(2'b11); hold(10);
            drive(2'b00); hold(10);
        end
        check("ccw3_leds", 32'(leds), 32'h20);
`ifdef ROTARY_SATURATE_EN
        check("ccw3_pos", 32'(position), 32'h00);
`else
        check("ccw3_pos", 32'(position), 32'hFD);
`endif

        // Short glitch on A while idle
        do_reset();
        p0 = pulse_cnt;
        drive(2'b10); hold(3);
        drive(2'b00); hold(15);
        check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("glitch_leds", 32'(leds), 32'h01);
        check("glitch_pos", 32'(position), 32'h00);
        drive(2'b01); hold(10);
        drive(2'b11); hold(10);
        drive(2'b00); hold(10);
        check("after_glitch_pos", 32'(position), 32'h01);

        // Reset lands on the edge a CW step would fire; the step is dropped
        do_reset();
        p0 = pulse_cnt;
        drive(2'b01); hold(10);
        drive(2'b11); hold(6);
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
        check("rstmid_valid", 32'(step_valid), 32'h0);
        check("rstmid_leds", 32'(leds), 32'h01);
        check("rstmid_pos", 32'(position), 32'h00);
        check("rstmid_dir", 32'(step_dir), 32'h0);
        hold(15);
        drive(2'b00); hold(10);
        check("rstmid_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("rstmid_leds2", 32'(leds), 32'h01);
        check("rstmid_pos2", 32'(position), 32'h00);
        drive(2'b01); hold(10);
        drive(2'b11); hold(10);
        drive(2'b00); hold(10);
        check("rstmid_recover_pos", 32'(position), 32'h01);
        check("rstmid_recover_leds", 32'(leds), 32'h02);

        // Randomized traffic against the detent model
        do_reset();
        pos = 0; idx = 0; prev = 0; latched = 1'b0;
        p0 = pulse_cnt;
        first = 0;
        sb_en = 1'b1;
        for (int s = 0; s < 160; s++) begin
            nv = $urandom_range(0, 3);
            m  = 1'($urandom_range(0, 1));
            mode = m;
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, 1);
                if (nv[b] == prev[b]) begin
                    drive(2'(prev ^ (1 << b)));
                    hold($urandom_range(1, DB - 1));
                end
            end
            drive(2'(nv));
            // A step fires on reaching 11 from a single-phase state, once per 00 visit.
            if (nv != prev) begin
                if (nv == 3) begin
                    if (!latched && (prev == 1 || prev == 2)) begin
                        first++;
                        if (prev == 1) begin
                            exp_q.push_back(1'b1);
`ifdef ROTARY_SATURATE_EN
                            pos = (pos == 255) ? 255 : pos + 1;
`else
                            pos = (pos + 1) % 256;
`endif
                            if (!m) idx = (idx + 1) % NL;
                        end else begin
                            exp_q.push_back(1'b0);
`ifdef ROTARY_SATURATE_EN
                            pos = (pos == 0) ? 0 : pos - 1;
`else
                            pos = (pos + 255) % 256;
`endif
                            if (!m) idx = (idx + NL - 1) % NL;
                        end
                    end
                    latched = 1'b1;
                end else if (nv == 0) begin
                    latched = 1'b0;
                end
                prev = nv;
            end
            hold($urandom_range(9, 12));
            w_pos = 8'(pos);
            exp_l = m ? w_pos : 8'(1 << idx);
            check("rand_pos", 32'(position), 32'(w_pos));
            check("rand_leds", 32'(leds), 32'(exp_l));
        end
        sb_en = 1'b0;
        check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rand_step_count", 32'(pulse_cnt - p0), 32'(first));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
